// File: rtl/clock_calendar_counter_if.sv
// Control inputs and BCD outputs of the clock/calendar core, bundled for the
// adjust buttons upstream and the Display block downstream.
interface clock_calendar_counter_if;
    logic        en_i;
    logic        tick_1hz_i;
    logic        dem_chinh_i;
    logic        smh_dmy_i;
    logic [1:0]  blink_led_i;
    logic        inc_i;
    logic        dec_i;
    logic [7:0]  bcd_ss_o;
    logic [7:0]  bcd_mm_o;
    logic [7:0]  bcd_hh_o;
    logic [7:0]  bcd_dd_o;
    logic [7:0]  bcd_mo_o;
    logic [15:0] bcd_yyyy_o;
    logic        day_pulse_o;

    modport master (
        output en_i, tick_1hz_i, dem_chinh_i, smh_dmy_i, blink_led_i, inc_i, dec_i,
        input  bcd_ss_o, bcd_mm_o, bcd_hh_o, bcd_dd_o, bcd_mo_o, bcd_yyyy_o, day_pulse_o
    );

    modport slave (
        input  en_i, tick_1hz_i, dem_chinh_i, smh_dmy_i, blink_led_i, inc_i, dec_i,
        output bcd_ss_o, bcd_mm_o, bcd_hh_o, bcd_dd_o, bcd_mo_o, bcd_yyyy_o, day_pulse_o
    );
endinterface

// File: rtl/clock_calendar_counter.sv
// BCD time/date counter with Gregorian leap rules, per-field manual adjust
// and a one-cycle midnight pulse.
module clock_calendar_counter #(
    parameter logic [15:0] RST_YEAR = 16'h2000
) (
    input  logic                     clk,
    input  logic                     rst,
    clock_calendar_counter_if.slave  bus
);

    logic [7:0]  ss_q, ss_d, mm_q, mm_d, hh_q, hh_d;
    logic [7:0]  dd_q, dd_d, mo_q, mo_d;
    logic [15:0] yyyy_q, yyyy_d;
    logic        day_pulse_q, day_pulse_d;
    logic        leap;
    logic [7:0]  dim;
    logic        step_up;

    // Values at or above hi wrap to lo, so a transiently oversized day also wraps.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi);
        if (v >= hi)
            return lo;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd2_dec(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi);
        if (v <= lo)
            return hi;
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

    function automatic logic [15:0] bcd4_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (up) begin
                    if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                    else begin r[4*i +: 4] = r[4*i +: 4] + 4'd1; c = 1'b0; end
                end else begin
                    if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                    else begin r[4*i +: 4] = r[4*i +: 4] - 4'd1; c = 1'b0; end
                end
            end
        end
        return r;
    endfunction

    // (2*tens + ones) mod 4; the 2-bit sum wraps naturally.
    function automatic logic [1:0] bcd_mod4(input logic [7:0] b);
        return {b[4], 1'b0} + b[1:0];
    endfunction

    always_comb begin
        if (yyyy_q[7:0] == 8'h00)
            leap = (bcd_mod4(yyyy_q[15:8]) == 2'd0);
        else
            leap = (bcd_mod4(yyyy_q[7:0]) == 2'd0);
        case (mo_q)
            8'h02:                      dim = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
            default:                    dim = 8'h31;
        endcase
    end

    always_comb begin
        ss_d        = ss_q;
        mm_d        = mm_q;
        hh_d        = hh_q;
        dd_d        = dd_q;
        mo_d        = mo_q;
        yyyy_d      = yyyy_q;
        day_pulse_d = 1'b0;
        step_up     = bus.inc_i;
        if (bus.en_i) begin
            // Clamp left over from the previous month/year change; any explicit update below wins.
            if (dd_q > dim)
                dd_d = dim;
            if (!bus.dem_chinh_i) begin
                if (bus.tick_1hz_i) begin
                    ss_d = bcd2_inc(ss_q, 8'h00, 8'h59);
                    if (ss_q == 8'h59) begin
                        mm_d = bcd2_inc(mm_q, 8'h00, 8'h59);
                        if (mm_q == 8'h59) begin
                            hh_d = bcd2_inc(hh_q, 8'h00, 8'h23);
                            if (hh_q == 8'h23) begin
                                day_pulse_d = 1'b1;
                                dd_d        = bcd2_inc(dd_q, 8'h01, dim);
                                if (dd_q >= dim) begin
                                    mo_d = bcd2_inc(mo_q, 8'h01, 8'h12);
                                    if (mo_q == 8'h12)
                                        yyyy_d = bcd4_step(yyyy_q, 1'b1);
                                end
                            end
                        end
                    end
                end
            end else if (bus.inc_i ^ bus.dec_i) begin
                case ({bus.smh_dmy_i, bus.blink_led_i})
                    3'b001: ss_d = step_up ? bcd2_inc(ss_q, 8'h00, 8'h59) : bcd2_dec(ss_q, 8'h00, 8'h59);
                    3'b010: mm_d = step_up ? bcd2_inc(mm_q, 8'h00, 8'h59) : bcd2_dec(mm_q, 8'h00, 8'h59);
                    3'b011: hh_d = step_up ? bcd2_inc(hh_q, 8'h00, 8'h23) : bcd2_dec(hh_q, 8'h00, 8'h23);
                    3'b101: dd_d = step_up ? bcd2_inc(dd_q, 8'h01, dim)   : bcd2_dec(dd_q, 8'h01, dim);
                    3'b110: mo_d = step_up ? bcd2_inc(mo_q, 8'h01, 8'h12) : bcd2_dec(mo_q, 8'h01, 8'h12);
                    3'b111: yyyy_d = bcd4_step(yyyy_q, step_up);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q        <= 8'h00;
            mm_q        <= 8'h00;
            hh_q        <= 8'h00;
            dd_q        <= 8'h01;
            mo_q        <= 8'h01;
            yyyy_q      <= RST_YEAR;
            day_pulse_q <= 1'b0;
        end else begin
            ss_q        <= ss_d;
            mm_q        <= mm_d;
            hh_q        <= hh_d;
            dd_q        <= dd_d;
            mo_q        <= mo_d;
            yyyy_q      <= yyyy_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    assign bus.bcd_ss_o    = ss_q;
    assign bus.bcd_mm_o    = mm_q;
    assign bus.bcd_hh_o    = hh_q;
    assign bus.bcd_dd_o    = dd_q;
    assign bus.bcd_mo_o    = mo_q;
    assign bus.bcd_yyyy_o  = yyyy_q;
    assign bus.day_pulse_o = day_pulse_q;

endmodule

// File: tb/tb_clock_calendar_counter.sv
// Bench for clock_calendar_counter: integer calendar model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_clock_calendar_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clock_calendar_counter_if bus();

    clock_calendar_counter #(.RST_YEAR(16'h2000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    int m_s, m_m, m_h, m_d, m_mo, m_y;
    bit m_dp;

    function automatic int days_in(input int mo, input int y);
        bit lp;
        lp = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
        if (mo == 2) return lp ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] to_bcd4(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_s = 0; m_m = 0; m_h = 0; m_d = 1; m_mo = 1; m_y = 2000; m_dp = 1'b0;
    endtask

    task automatic model_step();
        int ns, nm, nh, nd, nmo, ny, dl, dm;
        bit ndp;
        ns = m_s; nm = m_m; nh = m_h; nd = m_d; nmo = m_mo; ny = m_y; ndp = 1'b0;
        dm = days_in(m_mo, m_y);
        if (bus.en_i) begin
            if (m_d > dm) nd = dm;
            if (!bus.dem_chinh_i) begin
                if (bus.tick_1hz_i) begin
                    ns = (m_s + 1) % 60;
                    if (m_s == 59) begin
                        nm = (m_m + 1) % 60;
                        if (m_m == 59) begin
                            nh = (m_h + 1) % 24;
                            if (m_h == 23) begin
                                ndp = 1'b1;
                                if (m_d >= dm) begin
                                    nd  = 1;
                                    nmo = m_mo % 12 + 1;
                                    if (m_mo == 12) ny = (m_y + 1) % 10000;
                                end else nd = m_d + 1;
                            end
                        end
                    end
                end
            end else if (bus.inc_i != bus.dec_i) begin
                dl = bus.inc_i ? 1 : -1;
                case ({bus.smh_dmy_i, bus.blink_led_i})
                    3'b001: ns  = (m_s + dl + 60) % 60;
                    3'b010: nm  = (m_m + dl + 60) % 60;
                    3'b011: nh  = (m_h + dl + 24) % 24;
                    3'b101: nd  = bus.inc_i ? ((m_d >= dm) ? 1 : m_d + 1) : ((m_d <= 1) ? dm : m_d - 1);
                    3'b110: nmo = (m_mo - 1 + dl + 12) % 12 + 1;
                    3'b111: ny  = (m_y + dl + 10000) % 10000;
                    default: ;
                endcase
            end
        end
        m_s = ns; m_m = nm; m_h = nh; m_d = nd; m_mo = nmo; m_y = ny; m_dp = ndp;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        if (!rst) model_step();
        #1;
        if (chk_on && !rst) begin
            chk("ss",   {8'h0, bus.bcd_ss_o}, {8'h0, to_bcd2(m_s)});
            chk("mm",   {8'h0, bus.bcd_mm_o}, {8'h0, to_bcd2(m_m)});
            chk("hh",   {8'h0, bus.bcd_hh_o}, {8'h0, to_bcd2(m_h)});
            chk("dd",   {8'h0, bus.bcd_dd_o}, {8'h0, to_bcd2(m_d)});
            chk("mo",   {8'h0, bus.bcd_mo_o}, {8'h0, to_bcd2(m_mo)});
            chk("yyyy", bus.bcd_yyyy_o, to_bcd4(m_y));
            chk("day_pulse", {15'h0, bus.day_pulse_o}, {15'h0, m_dp});
        end
    end

    function automatic int mfield(input logic [2:0] sel);
        case (sel)
            3'b001: return m_s;
            3'b010: return m_m;
            3'b011: return m_h;
            3'b101: return m_d;
            3'b110: return m_mo;
            default: return m_y;
        endcase
    endfunction

    function automatic int mrange(input logic [2:0] sel);
        case (sel)
            3'b001, 3'b010: return 60;
            3'b011: return 24;
            3'b101: return days_in(m_mo, m_y);
            3'b110: return 12;
            default: return 10000;
        endcase
    endfunction

    // Steps one field toward target through adjust pulses; expects adjust mode and negedge.
    task automatic set_field(input logic [2:0] sel, input int target);
        int cur, r, up, guard;
        bus.smh_dmy_i   = sel[2];
        bus.blink_led_i = sel[1:0];
        guard = 0;
        cur = mfield(sel);
        while (cur != target && guard < 6000) begin
            r  = mrange(sel);
            up = (target - cur + r) % r;
            if (up <= r / 2) bus.inc_i = 1'b1; else bus.dec_i = 1'b1;
            @(negedge clk);
            bus.inc_i = 1'b0; bus.dec_i = 1'b0;
            @(negedge clk);
            guard++;
            cur = mfield(sel);
        end
        n_tests++;
        if (cur != target) begin
            n_fail++;
            $display("FAIL set_field timeout: sel %b reached %0d, required %0d", sel, cur, target);
        end
    endtask

    task automatic preload(input int h, input int mi, input int s, input int d, input int mo, input int y);
        bus.dem_chinh_i = 1'b1;
        @(negedge clk);
        set_field(3'b111, y);
        set_field(3'b110, mo);
        set_field(3'b101, d);
        set_field(3'b011, h);
        set_field(3'b010, mi);
        set_field(3'b001, s);
        bus.blink_led_i = 2'b00;
    endtask

    task automatic tick_once();
        bus.dem_chinh_i = 1'b0;
        bus.blink_led_i = 2'b00;
        @(negedge clk);
        bus.tick_1hz_i = 1'b1;
        @(negedge clk);
        bus.tick_1hz_i = 1'b0;
    endtask

    task automatic pulse(input bit up, input bit dn);
        bus.inc_i = up; bus.dec_i = dn;
        @(negedge clk);
        bus.inc_i = 1'b0; bus.dec_i = 1'b0;
    endtask

    task automatic chk_date(input string name, input logic [7:0] d, input logic [7:0] mo,
                            input logic [15:0] y);
        chk({name, "_dd"},   {8'h0, bus.bcd_dd_o}, {8'h0, d});
        chk({name, "_mo"},   {8'h0, bus.bcd_mo_o}, {8'h0, mo});
        chk({name, "_yyyy"}, bus.bcd_yyyy_o, y);
    endtask

    task automatic chk_time(input string name, input logic [7:0] h, input logic [7:0] mi,
                            input logic [7:0] s);
        chk({name, "_hh"}, {8'h0, bus.bcd_hh_o}, {8'h0, h});
        chk({name, "_mm"}, {8'h0, bus.bcd_mm_o}, {8'h0, mi});
        chk({name, "_ss"}, {8'h0, bus.bcd_ss_o}, {8'h0, s});
    endtask

    initial begin
        bus.en_i = 1'b1; bus.tick_1hz_i = 1'b0; bus.dem_chinh_i = 1'b0;
        bus.smh_dmy_i = 1'b0; bus.blink_led_i = 2'b00; bus.inc_i = 1'b0; bus.dec_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        chk_time("reset", 8'h00, 8'h00, 8'h00);
        chk_date("reset", 8'h01, 8'h01, 16'h2000);
        chk("reset_day_pulse", {15'h0, bus.day_pulse_o}, 16'h0);

        preload(23, 59, 59, 31, 12, 2099);
        tick_once();
        chk_time("rollover", 8'h00, 8'h00, 8'h00);
        chk_date("rollover", 8'h01, 8'h01, 16'h2100);
        chk("rollover_pulse_hi", {15'h0, bus.day_pulse_o}, 16'h1);
        @(negedge clk);
        chk("rollover_pulse_lo", {15'h0, bus.day_pulse_o}, 16'h0);

        preload(23, 59, 59, 28, 2, 2024);
        tick_once();
        chk_date("leap2024", 8'h29, 8'h02, 16'h2024);
        preload(23, 59, 59, 28, 2, 2100);
        tick_once();
        chk_date("leap2100", 8'h01, 8'h03, 16'h2100);
        preload(23, 59, 59, 28, 2, 2000);
        tick_once();
        chk_date("leap2000", 8'h29, 8'h02, 16'h2000);

        preload(5, 59, 10, 15, 6, 2030);
        bus.smh_dmy_i = 1'b0; bus.blink_led_i = 2'b10;
        pulse(1'b1, 1'b0);
        chk_time("adj_inc", 8'h05, 8'h00, 8'h10);
        pulse(1'b0, 1'b1);
        chk_time("adj_dec", 8'h05, 8'h59, 8'h10);
        pulse(1'b1, 1'b1);
        chk_time("adj_both", 8'h05, 8'h59, 8'h10);

        preload(12, 0, 0, 31, 3, 2023);
        bus.smh_dmy_i = 1'b1; bus.blink_led_i = 2'b10;
        pulse(1'b0, 1'b1);
        chk_date("clamp_mid", 8'h31, 8'h02, 16'h2023);
        @(negedge clk);
        chk_date("clamp_done", 8'h28, 8'h02, 16'h2023);
        set_field(3'b111, 2024);
        set_field(3'b101, 29);
        bus.smh_dmy_i = 1'b1; bus.blink_led_i = 2'b11;
        pulse(1'b0, 1'b1);
        @(negedge clk);
        chk_date("clamp_year", 8'h28, 8'h02, 16'h2023);

        bus.blink_led_i = 2'b00;
        repeat (100) begin
            bus.tick_1hz_i = 1'b1; @(negedge clk);
            bus.tick_1hz_i = 1'b0; @(negedge clk);
        end
        chk_time("freeze_adj", 8'h12, 8'h00, 8'h00);
        bus.en_i = 1'b0; bus.dem_chinh_i = 1'b0;
        repeat (20) begin
            bus.tick_1hz_i = 1'b1; bus.inc_i = 1'b1; @(negedge clk);
        end
        bus.tick_1hz_i = 1'b0; bus.inc_i = 1'b0;
        chk_time("freeze_en", 8'h12, 8'h00, 8'h00);
        bus.en_i = 1'b1;

        preload(23, 59, 58, 31, 12, 2050);
        bus.dem_chinh_i = 1'b0;
        bus.tick_1hz_i = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk_time("async_rst", 8'h00, 8'h00, 8'h00);
        chk_date("async_rst", 8'h01, 8'h01, 16'h2000);
        bus.tick_1hz_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        preload(23, 59, 30, 28, 2, 2096);
        for (int i = 0; i < 4000; i++) begin
            bus.en_i        = ($urandom_range(0, 15) != 0);
            bus.tick_1hz_i  = $urandom_range(0, 1);
            if ($urandom_range(0, 40) == 0) bus.dem_chinh_i = ~bus.dem_chinh_i;
            if ($urandom_range(0, 10) == 0) begin
                bus.smh_dmy_i   = $urandom_range(0, 1);
                bus.blink_led_i = 2'($urandom_range(0, 3));
            end
            bus.inc_i = ($urandom_range(0, 3) == 0);
            bus.dec_i = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        bus.tick_1hz_i = 1'b0; bus.inc_i = 1'b0; bus.dec_i = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
